// File: rtl/hbridge_gate_ctrl_pkg.sv
// Shared drivetrain definitions: bridge states, request codes, gate map and default timing.
// Pure declarations; no latency and no flow control.
package hbridge_gate_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_DEAD  = 3'd1,
    ST_FWD   = 3'd2,
    ST_REV   = 3'd3,
    ST_BRAKE = 3'd4,
    ST_FAULT = 3'd5
  } bridge_state_e;

  // {pwm_a, pwm_b} request codes
  localparam logic [1:0] REQ_OFF   = 2'b00;
  localparam logic [1:0] REQ_REV   = 2'b01;
  localparam logic [1:0] REQ_FWD   = 2'b10;
  localparam logic [1:0] REQ_BRAKE = 2'b11;

  localparam int DEAD_CYCLES_DEF = 50;
  localparam int FAULT_FILT_DEF  = 4;

  typedef struct packed {
    logic ha;
    logic la;
    logic hb;
    logic lb;
  } gates_t;

  function automatic bridge_state_e decode_req(input logic [1:0] req);
    case (req)
      REQ_FWD:   return ST_FWD;
      REQ_REV:   return ST_REV;
      REQ_BRAKE: return ST_BRAKE;
      default:   return ST_OFF;
    endcase
  endfunction

  // Only conducting states drive gates; each leg never gets both switches.
  function automatic gates_t gate_map(input bridge_state_e st);
    gates_t g;
    g = '0;
    case (st)
      ST_FWD:   begin g.ha = 1'b1; g.lb = 1'b1; end
      ST_REV:   begin g.hb = 1'b1; g.la = 1'b1; end
      ST_BRAKE: begin g.la = 1'b1; g.lb = 1'b1; end
      default:  g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/hbridge_gate_ctrl_fault_filter.sv
// Over-current filter: 2-flop sync of fault_n, then a consecutive-low counter.
// fault_det_o pulses one cycle, registered, on the clk the count reaches FAULT_FILT; no backpressure.
module hbridge_gate_ctrl_fault_filter
  import hbridge_gate_ctrl_pkg::*;
#(
  parameter int FAULT_FILT = FAULT_FILT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fault_n_i,
  output logic fault_ok_o,
  output logic fault_det_o
);

  localparam int FW = $clog2(FAULT_FILT + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FAULT_FILT);

  logic [1:0]    sync_q;
  logic [FW-1:0] cnt_q, cnt_d;
  logic          det_q;

  always_comb begin
    cnt_d = cnt_q;
    if (sync_q[1]) begin
      cnt_d = '0;
    end else if (cnt_q != FILT_MAX) begin
      cnt_d = cnt_q + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      det_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], fault_n_i};
      cnt_q  <= cnt_d;
      // Edge of saturation only, so a held fault yields a single detection.
      det_q  <= (cnt_d == FILT_MAX) && (cnt_q != FILT_MAX);
    end
  end

  assign fault_ok_o  = sync_q[1];
  assign fault_det_o = det_q;

endmodule

// File: rtl/hbridge_gate_ctrl.sv
// H-bridge gate sequencer with dead time, brake decode and latched filtered fault.
// Gates follow a request change after 1 clk (plus DEAD_CYCLES when leaving a conducting state); no backpressure.
module hbridge_gate_ctrl
  import hbridge_gate_ctrl_pkg::*;
#(
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEF,
  parameter int FAULT_FILT  = FAULT_FILT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwm_a,
  input  logic       pwm_b,
  input  logic       fault_n,
  input  logic       fault_clr,
  output logic       gate_ha,
  output logic       gate_la,
  output logic       gate_hb,
  output logic       gate_lb,
  output logic       dead_active,
  output logic       fault_latched,
  output logic [2:0] bridge_state
);

  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES - 1);

  bridge_state_e state_q, state_d, req_state;
  logic [DW-1:0] dcnt_q, dcnt_d;
  gates_t        gates_q;
  logic          dead_q, flt_q;
  logic          fault_ok, fault_det;

  hbridge_gate_ctrl_fault_filter #(
    .FAULT_FILT(FAULT_FILT)
  ) u_fault_filter (
    .clk        (clk),
    .rst_n      (rst_n),
    .fault_n_i  (fault_n),
    .fault_ok_o (fault_ok),
    .fault_det_o(fault_det)
  );

  assign req_state = decode_req({pwm_a, pwm_b});

  // Priority: fault detection, then fault clear, then request-driven moves.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    if (fault_det) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_OFF: state_d = req_state;
        ST_FWD, ST_REV, ST_BRAKE: begin
          if (req_state != state_q) begin
            state_d = ST_DEAD;
            dcnt_d  = DEAD_LOAD;
          end
        end
        ST_DEAD: begin
          if (dcnt_q == '0) begin
            state_d = req_state;
          end else begin
            dcnt_d = dcnt_q - DW'(1);
          end
        end
        ST_FAULT: begin
          if (fault_clr && fault_ok) begin
            state_d = ST_OFF;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // Outputs are decoded from the next state so they align with state_q glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      dcnt_q  <= '0;
      gates_q <= '0;
      dead_q  <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      gates_q <= gate_map(state_d);
      dead_q  <= (state_d == ST_DEAD);
      flt_q   <= (state_d == ST_FAULT);
    end
  end

  assign gate_ha       = gates_q.ha;
  assign gate_la       = gates_q.la;
  assign gate_hb       = gates_q.hb;
  assign gate_lb       = gates_q.lb;
  assign dead_active   = dead_q;
  assign fault_latched = flt_q;
  assign bridge_state  = state_q;

endmodule

// File: tb/tb_hbridge_gate_ctrl.sv
// Bench for hbridge_gate_ctrl: directed scenarios then random traffic against a cycle model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_hbridge_gate_ctrl;

  localparam int DC = 50;
  localparam int FF = 4;

  localparam int M_OFF   = 0;
  localparam int M_DEAD  = 1;
  localparam int M_FWD   = 2;
  localparam int M_REV   = 3;
  localparam int M_BRAKE = 4;
  localparam int M_FAULT = 5;

  logic       clk;
  logic       rst_n;
  logic       pwm_a, pwm_b, fault_n, fault_clr;
  logic       gate_ha, gate_la, gate_hb, gate_lb;
  logic       dead_active, fault_latched;
  logic [2:0] bridge_state;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_mode;
  int m_dead_left;
  int m_run;
  bit m_s1, m_s2, m_det;

  hbridge_gate_ctrl #(
    .DEAD_CYCLES(DC),
    .FAULT_FILT (FF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pwm_a        (pwm_a),
    .pwm_b        (pwm_b),
    .fault_n      (fault_n),
    .fault_clr    (fault_clr),
    .gate_ha      (gate_ha),
    .gate_la      (gate_la),
    .gate_hb      (gate_hb),
    .gate_lb      (gate_lb),
    .dead_active  (dead_active),
    .fault_latched(fault_latched),
    .bridge_state (bridge_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int req_mode(input logic a, input logic b);
    if (a && b) return M_BRAKE;
    if (a)      return M_FWD;
    if (b)      return M_REV;
    return M_OFF;
  endfunction

  // {ha, la, hb, lb}
  function automatic logic [3:0] exp_gates(input int mode);
    case (mode)
      M_FWD:   return 4'b1001;
      M_REV:   return 4'b0110;
      M_BRAKE: return 4'b0101;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_reset();
    m_mode      = M_OFF;
    m_dead_left = 0;
    m_run       = 0;
    m_s1        = 1'b1;
    m_s2        = 1'b1;
    m_det       = 1'b0;
  endtask

  // One clock edge of the model: mode transition from pre-edge values, then fault pipeline.
  task automatic model_edge();
    int req;
    req = req_mode(pwm_a, pwm_b);
    if (m_det) begin
      m_mode = M_FAULT;
    end else if (m_mode == M_FAULT) begin
      if (fault_clr && m_s2) m_mode = M_OFF;
    end else if (m_mode == M_OFF) begin
      m_mode = req;
    end else if (m_mode == M_DEAD) begin
      m_dead_left = m_dead_left - 1;
      if (m_dead_left == 0) m_mode = req;
    end else if (req != m_mode) begin
      m_mode      = M_DEAD;
      m_dead_left = DC;
    end
    if (m_s2) begin
      m_run = 0;
      m_det = 1'b0;
    end else begin
      m_run = m_run + 1;
      m_det = (m_run == FF);
    end
    m_s2 = m_s1;
    m_s1 = fault_n;
  endtask

  task automatic check_outputs(input string tag);
    checks++;
    assert (bridge_state === 3'(m_mode)) else begin
      errors++;
      $error("FAIL %s bridge_state got %0d exp %0d", tag, bridge_state, m_mode);
    end
    checks++;
    assert ({gate_ha, gate_la, gate_hb, gate_lb} === exp_gates(m_mode)) else begin
      errors++;
      $error("FAIL %s gates got %b exp %b", tag, {gate_ha, gate_la, gate_hb, gate_lb},
             exp_gates(m_mode));
    end
    checks++;
    assert (dead_active === (m_mode == M_DEAD)) else begin
      errors++;
      $error("FAIL %s dead_active got %b exp %b", tag, dead_active, (m_mode == M_DEAD));
    end
    checks++;
    assert (fault_latched === (m_mode == M_FAULT)) else begin
      errors++;
      $error("FAIL %s fault_latched got %b exp %b", tag, fault_latched, (m_mode == M_FAULT));
    end
    checks++;
    assert (!(gate_ha && gate_la) && !(gate_hb && gate_lb)) else begin
      errors++;
      $error("FAIL %s shoot_through got ha%b la%b hb%b lb%b exp no leg pair", tag,
             gate_ha, gate_la, gate_hb, gate_lb);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    assert ({gate_ha, gate_la, gate_hb, gate_lb, dead_active, fault_latched, bridge_state} === 9'd0)
    else begin
      errors++;
      $error("FAIL %s async_reset got %b exp 0", tag,
             {gate_ha, gate_la, gate_hb, gate_lb, dead_active, fault_latched, bridge_state});
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got == exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Steps until the DUT reports target, counting DEAD cycles seen; bounded.
  task automatic run_until(input string tag, input int target, input int budget,
                           output int dead_seen);
    bit reached;
    dead_seen = 0;
    reached   = 1'b0;
    for (int i = 0; i < budget && !reached; i++) begin
      step(tag);
      if (dead_active === 1'b1) dead_seen++;
      if (bridge_state === 3'(target)) reached = 1'b1;
    end
    check_int({tag, "_reached"}, int'(reached), 1);
  endtask

  initial begin
    int dead_seen;
    int lat;

    rst_n     = 1'b0;
    pwm_a     = 1'b0;
    pwm_b     = 1'b0;
    fault_n   = 1'b1;
    fault_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    check_outputs("reset");
    rst_n = 1'b1;
    step("idle");

    pwm_a = 1'b1;
    step("fwd_entry");
    check_int("fwd_state", int'(bridge_state), M_FWD);

    pwm_a = 1'b0; pwm_b = 1'b1;
    run_until("fwd_to_rev", M_REV, 120, dead_seen);
    check_int("fwd_to_rev_dead", dead_seen, DC);

    pwm_a = 1'b1; pwm_b = 1'b0;
    run_until("rev_to_fwd", M_FWD, 120, dead_seen);
    pwm_a = 1'b1; pwm_b = 1'b1;
    run_until("fwd_to_brake", M_BRAKE, 120, dead_seen);
    check_int("fwd_to_brake_dead", dead_seen, DC);
    pwm_a = 1'b0; pwm_b = 1'b0;
    run_until("brake_to_off", M_OFF, 120, dead_seen);
    check_int("brake_to_off_dead", dead_seen, DC);
    pwm_a = 1'b1;
    step("off_to_fwd");
    check_int("off_to_fwd_state", int'(bridge_state), M_FWD);

    pwm_a = 1'b0; pwm_b = 1'b1;
    run_until("to_rev", M_REV, 120, dead_seen);

    fault_n = 1'b0;
    repeat (3) step("glitch");
    fault_n = 1'b1;
    repeat (10) step("glitch_after");
    check_int("glitch_no_fault", int'(fault_latched), 0);

    fault_n = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && fault_latched !== 1'b1; i++) begin
      step("fault_lat");
      lat++;
    end
    check_int("fault_latency", lat, 2 + FF + 1);

    fault_clr = 1'b1;
    step("clr_ignored");
    fault_clr = 1'b0;
    step("clr_ignored_hold");
    check_int("clr_ignored_state", int'(fault_latched), 1);

    fault_n = 1'b1;
    repeat (2) step("release");
    fault_clr = 1'b1;
    step("clr");
    fault_clr = 1'b0;
    check_int("clr_to_off", int'(bridge_state), M_OFF);
    step("after_clr");
    check_int("after_clr_rev", int'(bridge_state), M_REV);

    pwm_a = 1'b1; pwm_b = 1'b0;
    repeat (5) step("mid_dead");
    rst_n = 1'b0;
    #2;
    check_all_zero("rst_mid_dead");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    step("post_rst_dead");
    check_int("post_rst_dead_fwd", int'(bridge_state), M_FWD);

    fault_n = 1'b0;
    repeat (8) step("to_fault");
    check_int("in_fault", int'(fault_latched), 1);
    rst_n   = 1'b0;
    fault_n = 1'b1;
    #2;
    check_all_zero("rst_mid_fault");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    step("post_rst_fault");
    check_int("post_rst_fault_fwd", int'(bridge_state), M_FWD);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) {pwm_a, pwm_b} = 2'($urandom_range(0, 3));
      if (fault_n) begin
        if ($urandom_range(0, 99) == 0) fault_n = 1'b0;
      end else begin
        if ($urandom_range(0, 3) == 0) fault_n = 1'b1;
      end
      fault_clr = ($urandom_range(0, 9) == 0);
      step("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hbridge_gate_ctrl.md
Name: hbridge_gate_ctrl

Overview:
- Downstream stage of the motor PWM generator. Consumes its two pulse outputs (forward/reverse drive requests) and produces the four H-bridge gate drives (HA, LA, HB, LB).
- Inserts programmable dead time on every change of bridge state, so the high and low switches of a leg are never on together.
- Decodes a simultaneous A+B request as low-side brake.
- Latches a filtered over-current fault that forces all gates off until it is explicitly cleared.

Parameters:
- DEAD_CYCLES, 50, clocks all-off between any two conducting states; legal range ≥1.
- FAULT_FILT, 4, consecutive synchronized fault_n-low cycles required to latch a fault; legal range ≥1.

Ports:
- clk  in  1  system clock, same domain as the PWM generator.
- rst_n  in  1  reset, asynchronous, active-low.
- pwm_a  in  1  forward drive request (PulseSignalA); synchronous to clk.
- pwm_b  in  1  reverse drive request (PulseSignalB); synchronous to clk.
- fault_n  in  1  over-current comparator, active-low; asynchronous to clk.
- fault_clr  in  1  single-cycle pulse that clears a latched fault.
- gate_ha  out  1  leg A high-side gate.
- gate_la  out  1  leg A low-side gate.
- gate_hb  out  1  leg B high-side gate.
- gate_lb  out  1  leg B low-side gate.
- dead_active  out  1  high while in DEAD.
- fault_latched  out  1  high while in FAULT.
- bridge_state  out  3  encoded FSM state: OFF=0, DEAD=1, FWD=2, REV=3, BRAKE=4, FAULT=5.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. While rst_n=0:
  - all gate outputs, dead_active and fault_latched are 0;
  - bridge_state=OFF;
  - dead counter, filter counter and fault synchronizer are cleared (synchronizer flops reset to 1).
- Request decode, combinational on {pwm_a,pwm_b}: 10→FWD, 01→REV, 11→BRAKE, 00→OFF.
- Gate map, all outputs registered:
  - FWD: ha=1, lb=1.
  - REV: hb=1, la=1.
  - BRAKE: la=1, lb=1.
  - OFF, DEAD and FAULT: all 0.
- Gate latency: 1 clk from request change to gate change.
- Illegal gate pairs: ha&la and hb&lb are never both 1 in any cycle, including across transitions.
- OFF:
  - stays in OFF while the request is OFF;
  - otherwise moves directly to the requested conducting state (1 clk latency), because the bridge is already fully off.
- FWD, REV or BRAKE:
  - while the request equals the current state, stay;
  - on any different request, including OFF, go to DEAD and load the counter with DEAD_CYCLES-1.
- DEAD:
  - all gates 0; the counter decrements each clk;
  - when the counter reaches 0, go to the state matching the request sampled in that same cycle (may be OFF);
  - the request is not latched at DEAD entry, so request changes during DEAD do not restart dead time.
  - Gates therefore stay off for exactly DEAD_CYCLES clks.
- Fault path:
  - fault_n passes through a 2-flop synchronizer;
  - the filter counter increments while the synchronized value is 0 and resets to 0 when it is 1;
  - when the count reaches FAULT_FILT, go to FAULT from any state, overriding DEAD and any request;
  - gates are 0 on the next clk.
  - Latency from a clean fault_n fall to gates off: 2 (sync) + FAULT_FILT + 1 clks.
- FAULT:
  - leave only when fault_clr=1 and the synchronized fault_n=1 in the same cycle; then go to OFF;
  - fault_clr while the fault is still present is ignored;
  - fault_clr outside FAULT has no effect.
- Simultaneous events: fault detection beats fault_clr beats request-driven transitions.
- Widths: dead counter $clog2(DEAD_CYCLES+1) bits; filter counter $clog2(FAULT_FILT+1) bits, saturating at FAULT_FILT.

Decomposition:
- Shared drivetrain package holds:
  - the bridge_state enum/localparams (OFF..FAULT);
  - the request decode constants;
  - the default DEAD_CYCLES and FAULT_FILT values.
- One natural sub-module: fault_filter (2-flop synchronizer plus consecutive-low counter). Its output is a single-cycle-valid fault_det.

Test Plan:
- Reset, then pwm_a=1, pwm_b=0 → after 1 clk ha=lb=1, la=hb=0, bridge_state=2.
- Request switches from FWD to REV (pwm_a=0, pwm_b=1), DEAD_CYCLES=50 → all gates 0 and dead_active=1 for exactly 50 clks, then hb=la=1, bridge_state=3. The checker asserts no shoot-through in every cycle.
- FWD, then pwm_a=pwm_b=1 → 50 clks all off, then la=lb=1, bridge_state=4. Dropping to 00 → 50 clks DEAD, then OFF. A following 10 → FWD after 1 clk with no dead time.
- During REV, pulse fault_n low for 3 clks (FAULT_FILT=4) → no fault. Hold it low for 4+ clks → gates 0 and fault_latched=1 at exactly 2+4+1 clks after the fall.
- In FAULT with fault_n still low, pulse fault_clr → remains in FAULT. Release fault_n, wait 2 clks, pulse fault_clr → OFF next clk, then the requested state follows after 1 clk.
- Assert rst_n=0 mid-DEAD and mid-FAULT → all outputs 0 immediately without waiting for a clk edge. After release with pwm_a=1, FWD is entered after 1 clk.
